adder_share_ctrl: RTL and testbench

- Two-requester round-robin controller that time-shares one external 64-bit ripple-carry adder.
- Latches the granted requester's operands and holds them on the adder inputs for a programmable settle window, because the ripple chain is treated as a multi-cycle path.
- Captures sum/cout/overflow and returns them to the owning requester over a valid/ready response handshake.
- Sits between client datapaths and the shared adder instance at the parent level.

---
 rtl/adder_share_pkg.sv | 13 +
 rtl/adder_share_ctrl_rr_arb2.sv | 15 +
 rtl/adder_share_ctrl.sv | 149 ++++++++++++++
 tb/tb_adder_share_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and constants for the round-robin adder-sharing controller.
package adder_share_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    RESP   = 2'b10
  } state_e;

endpackage

// File: rtl/adder_share_ctrl_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a contended pick goes to the
// requester that did not win last time.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_winner,
  output logic grant
);

  always_comb begin
    if (valid0 && valid1) grant = ~last_winner;
    else                  grant = valid1;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one external ripple-carry adder between two requesters, holding the
// accepted operands for SETTLE_CYCLES before sampling the adder's result.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_overflow,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_overflow,
  output logic             busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("adder_share_ctrl: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_winner_q, last_winner_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               grant;
  logic               accept;
  logic               rsp_take;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_winner (last_winner_q),
    .grant       (grant)
  );

  // grant always names a valid requester when at least one is valid.
  assign accept   = (state_q == IDLE) && (req0_valid || req1_valid);
  assign rsp_take = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      owner_q       <= 1'b0;
      last_winner_q <= 1'b1;
      op_a_q        <= '0;
      op_b_q        <= '0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      sum_q         <= sum_d;
      cout_q        <= cout_d;
      ovf_q         <= ovf_d;
    end
  end

  always_comb begin
    // NOTE: each _d starts from its _q, so branches that leave it untouched
    // hold the register instead of inferring a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    sum_d         = sum_q;
    cout_d        = cout_q;
    ovf_d         = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          op_a_d  = grant ? req1_a : req0_a;
          op_b_d  = grant ? req1_b : req0_b;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          sum_d   = add_sum;
          cout_d  = add_cout;
          ovf_d   = add_overflow;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Fairness is tied to completion, so a stalled owner does not lose its turn.
        if (rsp_take) begin
          last_winner_d = owner_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && req0_valid && !grant;
    req1_ready = (state_q == IDLE) && req1_valid &&  grant;
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) &&  owner_q;
    busy       = (state_q != IDLE);
  end

  assign add_a        = op_a_q;
  assign add_b        = op_b_q;
  assign rsp_sum      = sum_q;
  assign rsp_cout     = cout_q;
  assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: vector table plus hand-written multi-cycle
// sequences, with a behavioural adder standing in for the shared instance.
module tb_adder_share_ctrl;

  localparam int W = 64;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_overflow;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cout, add_overflow, busy;
  logic         ovf_flip;

  // Behavioural adder; ovf_flip inverts the overflow flag to prove it is passed through raw.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};
  assign add_overflow = ((add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1])) ^ ovf_flip;

  adder_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .add_overflow(add_overflow), .busy(busy)
  );

  // Second instance with the shortest legal settle window.
  logic         s_valid, s_ready, s_req1_ready, s_rsp_valid, s_rsp_ready, s_rsp1_valid;
  logic [W-1:0] s_a, s_b, s_sum, s_add_a, s_add_b, s_add_sum;
  logic         s_cout, s_ovf, s_add_cout, s_busy;

  assign {s_add_cout, s_add_sum} = {1'b0, s_add_a} + {1'b0, s_add_b};

  adder_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_valid), .req0_ready(s_ready), .req0_a(s_a), .req0_b(s_b),
    .req1_valid(1'b0), .req1_ready(s_req1_ready), .req1_a('0), .req1_b('0),
    .rsp0_valid(s_rsp_valid), .rsp0_ready(s_rsp_ready),
    .rsp1_valid(s_rsp1_valid), .rsp1_ready(1'b0),
    .rsp_sum(s_sum), .rsp_cout(s_cout), .rsp_overflow(s_ovf),
    .add_a(s_add_a), .add_b(s_add_b), .add_sum(s_add_sum), .add_cout(s_add_cout),
    .add_overflow(1'b0), .busy(s_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flip;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [6];

  // One complete operation: accept, scrambled inputs during settle, latency, result, handshake.
  task automatic run_op(input vec_t v);
    int lat;
    bit seen;
    bit stable;
    @(negedge clk);
    ovf_flip = v.flip;
    if (v.sel) begin req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; end
    else       begin req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; end
    #1;
    check_b({v.name, " own ready"},   v.sel ? req1_ready : req0_ready, 1'b1);
    check_b({v.name, " other ready"}, v.sel ? req0_ready : req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~v.a; req0_b = ~v.b; req1_a = ~v.a; req1_b = ~v.b;
    lat = 1; seen = 1'b0; stable = 1'b1;
    while (!seen && lat < 40) begin
      if (v.sel ? rsp1_valid : rsp0_valid) seen = 1'b1;
      else begin
        if (add_a !== v.a || add_b !== v.b) stable = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
    check_b({v.name, " operands stable"}, stable, 1'b1);
    check_i({v.name, " latency"}, lat, S + 1);
    check  ({v.name, " sum"},  rsp_sum, v.exp_sum);
    check_b({v.name, " cout"}, rsp_cout, v.exp_cout);
    check_b({v.name, " ovf"},  rsp_overflow, v.exp_ovf);
    check_b({v.name, " other rsp valid"}, v.sel ? rsp0_valid : rsp1_valid, 1'b0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    check_b({v.name, " rsp done"}, rsp0_valid | rsp1_valid, 1'b0);
    check_b({v.name, " idle"}, busy, 1'b0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit both;
    bit order[4];
    bit ok;
    logic [W-1:0] held;

    vecs[0] = '{"single",   1'b0, 64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0};
    vecs[1] = '{"carry",    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{"pos_ovf",  1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{"neg_ovf",  1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[4] = '{"nocarry",  1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{"ovf_raw",  1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5B, 1'b1, 64'h0, 1'b1, 1'b1};

    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0; ovf_flip = 1'b0;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check_b("reset busy", busy, 1'b0);
    check_b("reset req ready", req0_ready | req1_ready, 1'b0);
    check_b("reset rsp valid", rsp0_valid | rsp1_valid, 1'b0);
    check  ("reset add_a", add_a, '0);
    check  ("reset add_b", add_b, '0);
    check  ("reset rsp_sum", rsp_sum, '0);
    check_b("reset cout/ovf", rsp_cout | rsp_overflow, 1'b0);

    // Contention from reset: both requesters valid, responses taken at once.
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 64'd10; req0_b = 64'd1; req1_a = 64'd20; req1_b = 64'd2;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    n = 0; both = 1'b0;
    for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready || req1_ready) begin
        order[n] = req1_ready;
        n++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && busy; cyc++) @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check_i("contention accepts", n, 4);
    check_b("contention never both ready", both, 1'b0);
    check_b("contention grant0", order[0], 1'b0);
    check_b("contention grant1", order[1], 1'b1);
    check_b("contention grant2", order[2], 1'b0);
    check_b("contention grant3", order[3], 1'b1);
    check_b("contention drained", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Backpressure: requester 0 stalls its response while requester 1 waits.
    req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd6; ovf_flip = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 64'd7; req1_b = 64'd8;
    for (int cyc = 0; cyc < 40 && !rsp0_valid; cyc++) @(negedge clk);
    held = 64'd11;
    ok = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (!rsp0_valid || rsp_sum !== held || !busy || req1_ready) ok = 1'b0;
      @(negedge clk);
    end
    check_b("stall held", ok, 1'b1);
    check  ("stall sum", rsp_sum, held);
    rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    check_b("stall released", rsp0_valid, 1'b0);
    check_b("stall req1 now ready", req1_ready, 1'b1);
    req1_valid = 1'b0; rsp0_ready = 1'b0;
    @(negedge clk);
    check_b("dropped valid no accept", busy, 1'b0);

    // Reset during the second settle cycle of a requester-1 op.
    req1_valid = 1'b1; req1_a = 64'hAAAA_AAAA_AAAA_AAAA; req1_b = 64'h1;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_b("async reset busy", busy, 1'b0);
    check  ("async reset add_a", add_a, '0);
    check  ("async reset add_b", add_b, '0);
    check  ("async reset rsp_sum", rsp_sum, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    ok = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (rsp0_valid || rsp1_valid || busy) ok = 1'b0;
      @(negedge clk);
    end
    check_b("no response after reset", ok, 1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_b("post-reset req0 wins", req0_ready, 1'b1);
    check_b("post-reset req1 waits", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && busy; cyc++) @(negedge clk);
    check_b("post-reset op done", busy, 1'b0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // SETTLE_CYCLES=1 instance: exactly one settle cycle, response two cycles after accept.
    s_valid = 1'b1; s_a = 64'd3; s_b = 64'd4;
    #1;
    check_b("s1 ready", s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_a = '0; s_b = '0;
    check_b("s1 settle busy", s_busy, 1'b1);
    check_b("s1 settle no rsp", s_rsp_valid, 1'b0);
    @(negedge clk);
    check_b("s1 rsp valid", s_rsp_valid, 1'b1);
    check  ("s1 sum", s_sum, 64'd7);
    check_b("s1 cout/ovf", s_cout | s_ovf, 1'b0);
    check_b("s1 side idle", s_req1_ready | s_rsp1_valid, 1'b0);
    s_rsp_ready = 1'b1;
    @(negedge clk);
    check_b("s1 done", s_busy | s_rsp_valid, 1'b0);
    s_rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
